// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  // Default geometry of the core's integer register file
  localparam int unsigned RF_WAD     = 5;
  localparam int unsigned RF_WD      = 32;
  localparam int unsigned RF_NRD     = 2;
  localparam int unsigned RF_DBG_REG = 10;

  // RISC-V ABI register indices
  localparam int unsigned X_ZERO = 0;
  localparam int unsigned X_RA   = 1;
  localparam int unsigned X_SP   = 2;
  localparam int unsigned X_GP   = 3;
  localparam int unsigned X_TP   = 4;
  localparam int unsigned X_T0   = 5;
  localparam int unsigned X_T1   = 6;
  localparam int unsigned X_T2   = 7;
  localparam int unsigned X_S0   = 8;
  localparam int unsigned X_S1   = 9;
  localparam int unsigned X_A0   = 10;
  localparam int unsigned X_A1   = 11;
  localparam int unsigned X_A2   = 12;
  localparam int unsigned X_A3   = 13;
  localparam int unsigned X_A4   = 14;
  localparam int unsigned X_A5   = 15;
  localparam int unsigned X_A6   = 16;
  localparam int unsigned X_A7   = 17;
  localparam int unsigned X_S2   = 18;
  localparam int unsigned X_S3   = 19;
  localparam int unsigned X_S4   = 20;
  localparam int unsigned X_S5   = 21;
  localparam int unsigned X_S6   = 22;
  localparam int unsigned X_S7   = 23;
  localparam int unsigned X_S8   = 24;
  localparam int unsigned X_S9   = 25;
  localparam int unsigned X_S10  = 26;
  localparam int unsigned X_S11  = 27;
  localparam int unsigned X_T3   = 28;
  localparam int unsigned X_T4   = 29;
  localparam int unsigned X_T5   = 30;
  localparam int unsigned X_T6   = 31;

  // Clear sequencer states
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Number of registers for a given address width
  function automatic int unsigned rf_depth(input int unsigned wad);
    return 32'(1) << wad;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks registers 1..2^WAD-1 one per cycle,
// then enters RUN and raises ready. Register 0 is never swept (hardwired zero).
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned WAD = RF_WAD
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           ready,
  output logic           clr_we_c,
  output logic [WAD-1:0] clr_addr_c
);

  localparam logic [WAD-1:0] PTR_FIRST = WAD'(1);
  localparam logic [WAD-1:0] PTR_LAST  = '1;

  rf_state_e      state_q, state_d;
  logic [WAD-1:0] ptr_q, ptr_d;

  // State register, sweep pointer and registered ready flag (sync reset)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= PTR_FIRST;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready   <= (state_d == RUN);
    end
  end

  // Next state: advance pointer through the sweep, stop at the last register
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (ptr_q == PTR_LAST) begin
          state_d = RUN;
        end else begin
          ptr_d = ptr_q + WAD'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = PTR_FIRST;
      end
    endcase
  end

  // Outputs: zero-write request for the current pointer while sweeping
  always_comb begin
    clr_we_c   = 1'b0;
    clr_addr_c = ptr_q;
    if (state_q == CLEAR) begin
      clr_we_c = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired x0, debug tap and
// post-reset clear sweep. Optional same-cycle write-to-read forwarding is
// enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WAD     = RF_WAD,
  parameter int unsigned WD      = RF_WD,
  parameter int unsigned NRD     = RF_NRD,
  parameter int unsigned DBG_REG = RF_DBG_REG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RegWrite,
  input  logic [WAD-1:0]          AdIn,
  input  logic [WD-1:0]           DIn,
  input  logic [NRD-1:0][WAD-1:0] AdOut,
  output logic [NRD-1:0][WD-1:0]  DOut,
  output logic [WD-1:0]           A0,
  output logic                    Ready
);

  localparam int unsigned    DEPTH    = rf_depth(WAD);
  localparam logic [WAD-1:0] DBG_ADDR = WAD'(DBG_REG);

  logic [WD-1:0]  mem [DEPTH];
  logic           clr_we_c;
  logic [WAD-1:0] clr_addr_c;
  logic           port_we_c;

  regfile_clear_seq #(
    .WAD (WAD)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (Ready),
    .clr_we_c   (clr_we_c),
    .clr_addr_c (clr_addr_c)
  );

  // Port write commits only in RUN, outside reset, and never to x0
  always_comb begin
    port_we_c = 1'b0;
    if (rst_n && Ready && RegWrite && (AdIn != '0)) begin
      port_we_c = 1'b1;
    end
  end

  // Storage write mux: sweep zeroing has priority, reset edges leave array untouched
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we_c) begin
        mem[clr_addr_c] <= '0;
      end else if (port_we_c) begin
        mem[AdIn] <= DIn;
      end
    end
  end

  // Read ports: zero while sweeping or for x0, optional forwarding of the committing write
  always_comb begin
    DOut = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (Ready && (AdOut[i] != '0)) begin
        DOut[i] = mem[AdOut[i]];
`ifdef REGFILE_BYPASS_EN
        if (port_we_c && (AdOut[i] == AdIn)) begin
          DOut[i] = DIn;
        end
`endif
      end
    end
  end

  // Debug tap: stored value only, never forwarded
  always_comb begin
    A0 = '0;
    if (Ready && (DBG_ADDR != '0)) begin
      A0 = mem[DBG_ADDR];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp (default geometry plus a
// small WAD=3/WD=16/NRD=3/DBG_REG=2 instance).
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic             rst_n;
  logic             reg_write;
  logic [4:0]       ad_in;
  logic [31:0]      d_in;
  logic [1:0][4:0]  adout;
  logic [1:0][31:0] dout;
  logic [31:0]      a0;
  logic             ready;

  // Small instance signals
  logic             s_rst_n;
  logic             s_we;
  logic [2:0]       s_ad;
  logic [15:0]      s_din;
  logic [2:0][2:0]  s_adout;
  logic [2:0][15:0] s_dout;
  logic [15:0]      s_a0;
  logic             s_ready;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RegWrite (reg_write),
    .AdIn     (ad_in),
    .DIn      (d_in),
    .AdOut    (adout),
    .DOut     (dout),
    .A0       (a0),
    .Ready    (ready)
  );

  regfile_mp #(
    .WAD     (3),
    .WD      (16),
    .NRD     (3),
    .DBG_REG (2)
  ) dut_s (
    .clk      (clk),
    .rst_n    (s_rst_n),
    .RegWrite (s_we),
    .AdIn     (s_ad),
    .DIn      (s_din),
    .AdOut    (s_adout),
    .DOut     (s_dout),
    .A0       (s_a0),
    .Ready    (s_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register contents and readiness
  logic [31:0] model [32];
  bit          m_ready = 1'b0;
  int          m_edges = 0;
  bit          armed   = 1'b0;

  // Expected read value for the current inputs
  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (!m_ready || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && reg_write && ad_in != 5'd0 && addr == ad_in) return d_in;
`endif
    return model[addr];
  endfunction

  // Model one rising edge: reset restarts the 31-edge sweep, after which all registers read zero
  task automatic model_edge(input logic r, input logic we, input logic [4:0] ad, input logic [31:0] din);
    if (!r) begin
      m_ready = 1'b0;
      m_edges = 0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == 31) begin
        m_ready = 1'b1;
        for (int k = 0; k < 32; k++) model[k] = 32'd0;
      end
    end else if (we && ad != 5'd0) begin
      model[ad] = din;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s dout%0d ad=%0d", tag, i, adout[i]), dout[i], exp_rd(adout[i]));
    check({tag, " a0"}, a0, m_ready ? model[10] : 32'd0);
    check({tag, " ready"}, 32'(ready), 32'(m_ready));
  endtask

  // Apply inputs for one cycle, check before and after the edge
  task automatic step(input logic r, input logic we, input logic [4:0] ad, input logic [31:0] din);
    rst_n = r; reg_write = we; ad_in = ad; d_in = din;
    #1;
    if (armed) check_outputs("pre");
    @(posedge clk);
    model_edge(r, we, ad, din);
    if (!r) armed = 1'b1;
    #1;
    if (armed) check_outputs("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] s_vals [3];
    logic [2:0]  s_regs [3];
    rst_n = 1'b0; reg_write = 1'b0; ad_in = '0; d_in = '0; adout = '0;
    s_rst_n = 1'b0; s_we = 1'b0; s_ad = '0; s_din = '0; s_adout = '0;
    @(posedge clk); #1;

    // Reset for 2 edges, then sweep with a write to x5 that must be ignored
    step(1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd5, 32'hCAFE0005);
    check("reset ready", 32'(ready), 32'd0);
    check("reset a0", a0, 32'd0);
    for (int e = 1; e <= 31; e++) begin
      adout[0] = 5'd5; adout[1] = 5'($urandom);
      step(1'b1, 1'b1, 5'd5, $urandom);
      check($sformatf("sweep ready e=%0d", e), 32'(ready), (e == 31) ? 32'd1 : 32'd0);
    end
    reg_write = 1'b0; #1;
    check("x5 after sweep", dout[0], 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      adout[0] = 5'(a); adout[1] = 5'(a + 1);
      step(1'b1, 1'b0, 5'd0, 32'd0);
      check($sformatf("cleared x%0d", a), dout[0], 32'd0);
      check($sformatf("cleared x%0d", a + 1), dout[1], 32'd0);
    end

    // Basic write/read through both ports and the debug tap
    adout[0] = 5'd10; adout[1] = 5'd10;
    step(1'b1, 1'b1, 5'd10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 5'd0, 32'd0);
    check("x10 port0", dout[0], 32'hDEADBEEF);
    check("x10 port1", dout[1], 32'hDEADBEEF);
    check("x10 a0", a0, 32'hDEADBEEF);

    // x0 protection
    adout[0] = 5'd0; adout[1] = 5'd0;
    step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 5'd0, 32'd0);
    check("x0 port0", dout[0], 32'd0);
    check("x0 port1", dout[1], 32'd0);

    // Read during write of x7
    adout[0] = 5'd7; adout[1] = 5'd10;
    step(1'b1, 1'b1, 5'd7, 32'h11);
    reg_write = 1'b1; ad_in = 5'd7; d_in = 32'h22; #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw x7 same cycle", dout[0], 32'h22);
`else
    check("rdw x7 same cycle", dout[0], 32'h11);
`endif
    check("rdw a0 no bypass", a0, 32'hDEADBEEF);
    step(1'b1, 1'b1, 5'd7, 32'h22);
    check("rdw x7 after edge", dout[0], 32'h22);

    // Debug tap must not forward a same-cycle write to x10
    reg_write = 1'b1; ad_in = 5'd10; d_in = 32'h12345678; #1;
    check("a0 no bypass x10", a0, 32'hDEADBEEF);

    // Mid-operation reset
    adout[0] = 5'd3; adout[1] = 5'd10;
    step(1'b1, 1'b1, 5'd3, 32'h55);
    step(1'b0, 1'b1, 5'd3, 32'h66);
    check("midreset ready", 32'(ready), 32'd0);
    check("midreset x3", dout[0], 32'd0);
    check("midreset a0", a0, 32'd0);
    for (int e = 0; e < 31; e++) step(1'b1, 1'b0, 5'd0, 32'd0);
    check("midreset ready back", 32'(ready), 32'd1);
    check("midreset x3 cleared", dout[0], 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic        r, we;
      logic [4:0]  ad;
      r  = ($urandom_range(0, 149) != 0);
      we = 1'($urandom);
      ad = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      adout[0] = 5'($urandom);
      adout[1] = ($urandom_range(0, 3) == 0) ? ad : 5'($urandom);
      if ($urandom_range(0, 3) == 0) adout[0] = ad;
      step(r, we, ad, $urandom);
    end

    // Small instance: 7-edge sweep, three independent ports
    s_vals[0] = 16'h1111; s_vals[1] = 16'h2222; s_vals[2] = 16'h7777;
    s_regs[0] = 3'd1;     s_regs[1] = 3'd2;     s_regs[2] = 3'd7;
    s_adout = {3'd7, 3'd2, 3'd1};
    s_we = 1'b1; s_ad = 3'd1; s_din = 16'hBAD0;
    @(posedge clk); @(posedge clk); #1;
    check("s reset ready", 32'(s_ready), 32'd0);
    s_rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      check($sformatf("s sweep ready e=%0d", e), 32'(s_ready), (e == 7) ? 32'd1 : 32'd0);
      if (e < 7) check($sformatf("s sweep dout0 e=%0d", e), 32'(s_dout[0]), 32'd0);
    end
    s_we = 1'b0; #1;
    check("s x1 cleared", 32'(s_dout[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      s_we = 1'b1; s_ad = s_regs[k]; s_din = s_vals[k];
      @(posedge clk); #1;
    end
    s_we = 1'b0; #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("s port%0d x%0d", k, s_regs[k]), 32'(s_dout[k]), 32'(s_vals[k]));
    check("s a0 x2", 32'(s_a0), 32'h2222);
    s_adout = {3'd1, 3'd7, 3'd0}; #1;
    check("s port0 x0", 32'(s_dout[0]), 32'd0);
    check("s port1 x7", 32'(s_dout[1]), 32'h7777);
    check("s port2 x1", 32'(s_dout[2]), 32'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file, the next-generation register file for the reduced RISC-V core. It provides `NRD` combinational read ports, one synchronous write port, a hardwired-zero `x0`, and a debug tap on a selectable register (default `a0`/`x10`). After reset, a clear sequencer zeroes every register one per cycle, and a `Ready` flag gates core operation. Optional write-to-read bypass supports same-cycle forwarding to decode.

## Interface
Parameters:
- `WAD`, 5, address width; depth is 2^WAD registers.
- `WD`, 32, data width.
- `NRD`, 2, number of read ports (1..4).
- `DBG_REG`, 10, register index driven on `A0`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `RegWrite`  in  1  write enable.
- `AdIn`  in  WAD  write address.
- `DIn`  in  WD  write data.
- `AdOut`  in  NRD×WAD  read addresses, one per port.
- `DOut`  out  NRD×WD  read data, one per port.
- `A0`  out  WD  contents of register `DBG_REG`.
- `Ready`  out  1  high once the clear sweep has completed.

## Operation
- FSM states: `CLEAR`, `RUN`.
- `rst_n` low at an edge: state ← `CLEAR`, clear pointer ← 1, `Ready` ← 0. Array contents are not otherwise touched.
- `CLEAR`: each edge with `rst_n` high writes 0 to `mem[ptr]` and increments `ptr`.
  - When `ptr` equals 2^WAD−1, that edge writes the last register and sets state ← `RUN` and `Ready` ← 1.
  - `ptr` never wraps to 0.
- `CLEAR`: `RegWrite` is ignored, and `DOut[i]` and `A0` are forced to 0.
- `RUN`: on an edge with `RegWrite`=1 and `AdIn`≠0, `mem[AdIn]` ← `DIn`. A write to `AdIn`=0 is discarded.
- Reads in `RUN`:
  - `DOut[i]` is 0 when `AdOut[i]`=0, else `mem[AdOut[i]]`.
  - Ports are independent; any number of ports may address the same register.
- `A0` = `mem[DBG_REG]`, unaffected by bypass. It is 0 if `DBG_REG`=0.
- Reset asserted mid-`CLEAR` or mid-`RUN` restarts the sweep at `ptr`=1 on that edge. `Ready` drops the same edge.
- `RegWrite` concurrent with reset assertion is discarded.

## Timing
- Write latency: 1 edge; the value is visible on non-bypassed reads after the edge.
- Read latency: combinational (0 cycles) from `AdOut`.
- Clear sweep: exactly 2^WAD−1 edges with `rst_n` high. For WAD=5, `Ready` rises after the 31st such edge.
- Reset values: `Ready`=0, `DOut[*]`=0, `A0`=0 from the first reset edge until `Ready`=1.
- Simultaneous write and read of the same address: governed by the Configuration section.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: in `RUN`, if `RegWrite`=1, `AdIn`≠0 and `AdOut[i]`=`AdIn`, then `DOut[i]` = `DIn` in the same cycle. This adds a combinational path from `DIn` to `DOut`.
- Undefined: `DOut[i]` returns the pre-write contents until the edge. There is no `DIn`→`DOut` path.

## Structure
- Package `regfile_pkg` holds:
  - the `rf_state_e` enum (`CLEAR`, `RUN`);
  - the default constants `RF_WAD`, `RF_WD`, `RF_NRD` and `RF_DBG_REG`, with `RF_DBG_REG` = 10;
  - the ABI register-index localparams (`X_ZERO`, `X_RA`, `X_SP`, `X_A0`, …).
- Sub-module `regfile_clear_seq` contains the FSM, the sweep pointer and `Ready`, and outputs clear-write enable/address.
- `regfile_mp` contains the storage array, the write mux (sweep vs. port), the read ports and the optional bypass.

## Test plan
- Reset sweep: hold `rst_n`=0 for 2 cycles, then release. `Ready`=0 for 31 edges and 1 after. All 32 registers read 0. `RegWrite`=1 to x5 during the sweep is ignored (x5 = 0).
- Basic write/read: write 0xDEADBEEF to x10. Next cycle `DOut[0]`(x10)=0xDEADBEEF, `DOut[1]`(x10)=0xDEADBEEF, `A0`=0xDEADBEEF.
- x0 protection: write 0xFFFFFFFF to x0. Both ports reading x0 return 0.
- Same-cycle read-during-write: x7=0x11, then write 0x22 to x7 while `AdOut[0]`=7. With `REGFILE_BYPASS_EN`: `DOut[0]`=0x22 that cycle. Without it: 0x11, then 0x22 after the edge. In both builds `A0` does not bypass.
- Mid-operation reset: after writing x3=0x55, pulse `rst_n`=0 for 1 edge. `Ready` drops the same edge, reads return 0, and after 31 edges x3 reads 0.
- Parameter sweep: WAD=3, WD=16, NRD=3, DBG_REG=2. `Ready` rises after 7 edges, and three ports read x1, x2, x7 independently with correct values.
